// File: rtl/draw_rect_ctl.sv
// Frame-synchronous position controller for draw_rect: the rectangle follows the
// pointer while the left button is held and falls under constant gravity once released.
module draw_rect_ctl #(
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600,
    parameter int RECT_W   = 60,
    parameter int RECT_L   = 90,
    parameter int INIT_X   = 0,
    parameter int INIT_Y   = 0,
    parameter int GRAVITY  = 1,
    parameter int VMAX     = 32
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  state_out,
    output logic        frame_tick
);

    localparam logic [11:0] XMAX    = 12'(SCREEN_W - RECT_W);
    localparam logic [11:0] FLOOR_Y = 12'(SCREEN_H - RECT_L);
    localparam logic [11:0] INIT_XV = 12'(INIT_X);
    localparam logic [11:0] INIT_YV = 12'(INIT_Y);
    localparam logic [7:0]  GRAV_V  = 8'(GRAVITY);
    localparam logic [7:0]  VMAX_V  = 8'(VMAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DRAG = 2'b01,
        ST_FALL = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] x_nxt, y_nxt;
    logic [7:0]  vel, vel_nxt;
    logic        vblnk_d;
    logic        tick;
    logic [11:0] cx, cy;
    logic [8:0]  vsum;
    logic [7:0]  vn;
    logic [12:0] yn;

    assign tick      = vblnk_in & ~vblnk_d;
    assign state_out = state;

    // Pointer clamped so the whole rectangle stays on screen.
    always_comb begin
        cx = (mouse_xpos > XMAX)    ? XMAX    : mouse_xpos;
        cy = (mouse_ypos > FLOOR_Y) ? FLOOR_Y : mouse_ypos;
    end

    // One step of the fall; the extra bit on yn keeps the floor compare free of wrap.
    always_comb begin
        vsum = {1'b0, vel} + {1'b0, GRAV_V};
        vn   = (vsum > {1'b0, VMAX_V}) ? VMAX_V : vsum[7:0];
        yn   = {1'b0, ypos} + {5'b0, vn};
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = xpos;
        y_nxt     = ypos;
        vel_nxt   = vel;
        case (state)
            ST_IDLE: begin
                if (tick && mouse_left) begin
                    state_nxt = ST_DRAG;
                    x_nxt     = cx;
                    y_nxt     = cy;
                end
            end
            ST_DRAG: begin
                if (tick) begin
                    if (mouse_left) begin
                        x_nxt = cx;
                        y_nxt = cy;
                    end else begin
                        state_nxt = ST_FALL;
                        vel_nxt   = 8'd0;
                    end
                end
            end
            ST_FALL: begin
                if (tick) begin
                    if (mouse_left) begin
                        state_nxt = ST_DRAG;
                        vel_nxt   = 8'd0;
                        x_nxt     = cx;
                        y_nxt     = cy;
                    end else if (yn >= {1'b0, FLOOR_Y}) begin
                        state_nxt = ST_IDLE;
                        vel_nxt   = 8'd0;
                        y_nxt     = FLOOR_Y;
                    end else begin
                        vel_nxt = vn;
                        y_nxt   = yn[11:0];
                    end
                end
            end
            default: begin
                // Illegal encoding recovers without waiting for a frame tick.
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            xpos       <= INIT_XV;
            ypos       <= INIT_YV;
            vel        <= 8'd0;
            vblnk_d    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            xpos       <= x_nxt;
            ypos       <= y_nxt;
            vel        <= vel_nxt;
            vblnk_d    <= vblnk_in;
            frame_tick <= tick;
        end
    end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Bench for draw_rect_ctl: frame-level behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_draw_rect_ctl;

    localparam int XMAX    = 740;
    localparam int FLOOR_Y = 510;
    localparam int VMAX    = 32;
    localparam int GRAVITY = 1;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic        mouse_left = 1'b0;
    logic [11:0] xpos, ypos;
    logic [1:0]  state_out;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    draw_rect_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .xpos       (xpos),
        .ypos       (ypos),
        .state_out  (state_out),
        .frame_tick (frame_tick)
    );

    // clock / reset
    always #5 pclk = ~pclk;

    // behavioural model: st 0 = idle, 1 = dragging, 2 = falling
    typedef struct {
        int st;
        int x;
        int y;
        int vel;
    } model_t;

    model_t m;
    bit     m_prev = 1'b1;
    bit     m_ft   = 1'b0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic model_t frame_step(model_t cur, bit left, int mx, int my);
        model_t r = cur;
        int vn;
        if (left) begin
            r.st  = 1;
            r.x   = imin(mx, XMAX);
            r.y   = imin(my, FLOOR_Y);
            r.vel = 0;
        end else if (cur.st == 1) begin
            r.st  = 2;
            r.vel = 0;
        end else if (cur.st == 2) begin
            vn = imin(cur.vel + GRAVITY, VMAX);
            if (cur.y + vn >= FLOOR_Y) begin
                r.st  = 0;
                r.y   = FLOOR_Y;
                r.vel = 0;
            end else begin
                r.y   = cur.y + vn;
                r.vel = vn;
            end
        end
        return r;
    endfunction

    always @(posedge pclk or posedge rst) begin
        if (rst) begin
            m      <= '{0, 0, 0, 0};
            m_prev <= 1'b1;
            m_ft   <= 1'b0;
        end else begin
            m_prev <= vblnk_in;
            m_ft   <= vblnk_in && !m_prev;
            if (vblnk_in && !m_prev)
                m <= frame_step(m, mouse_left, int'(mouse_xpos), int'(mouse_ypos));
        end
    end

    // scoreboard
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (cmp_en) begin
            check("cyc_xpos", int'(xpos), m.x);
            check("cyc_ypos", int'(ypos), m.y);
            check("cyc_state", int'(state_out), m.st);
            check("cyc_frame_tick", int'(frame_tick), int'(m_ft));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_frame(input bit left, input int mx, input int my,
                               input int lo, input int hi, input bit junk);
        vblnk_in = 1'b0;
        for (int i = 0; i < lo; i++) begin
            if (junk) begin
                mouse_left = 1'($urandom_range(0, 1));
                mouse_xpos = 12'($urandom_range(0, 4095));
                mouse_ypos = 12'($urandom_range(0, 4095));
            end
            step();
        end
        vblnk_in   = 1'b1;
        mouse_left = left;
        mouse_xpos = 12'(mx);
        mouse_ypos = 12'(my);
        step();
        for (int i = 1; i < hi; i++) begin
            if (junk) begin
                mouse_left = 1'($urandom_range(0, 1));
                mouse_xpos = 12'($urandom_range(0, 4095));
                mouse_ypos = 12'($urandom_range(0, 4095));
            end
            step();
        end
    endtask

    task automatic check_pos(input string name, input int ex, input int ey, input int est);
        check({name, "_x"}, int'(xpos), ex);
        check({name, "_y"}, int'(ypos), ey);
        check({name, "_state"}, int'(state_out), est);
    endtask

    int fall_y[5] = '{1, 3, 6, 10, 15};

    initial begin
        #2 rst = 1'b1;
        step();
        step();
        check_pos("por", 0, 0, 0);
        check("por_frame_tick", int'(frame_tick), 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        step();

        // drag clamp
        drive_frame(1'b1, 790, 595, 2, 2, 1'b0);
        check_pos("drag_clamp", 740, 510, 1);

        // reset mid-frame with vblnk high: no tick right after release
        rst = 1'b1;
        #1;
        check_pos("rst_mid", 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        check("rst_no_tick", int'(frame_tick), 0);
        step();
        check("rst_no_tick2", int'(frame_tick), 0);

        // fall profile from y = 0
        drive_frame(1'b1, 100, 0, 2, 2, 1'b0);
        check_pos("grab", 100, 0, 1);
        drive_frame(1'b0, 5, 5, 2, 2, 1'b0);
        check_pos("release", 100, 0, 2);
        for (int k = 0; k < 5; k++) begin
            drive_frame(1'b0, 300, 300, 2, 2, 1'b0);
            check("fall_profile_y", int'(ypos), fall_y[k]);
        end
        for (int k = 5; k < 31; k++)
            drive_frame(1'b0, 300, 300, 2, 2, 1'b0);
        check_pos("fall_31", 100, 496, 2);
        drive_frame(1'b0, 300, 300, 2, 2, 1'b0);
        check_pos("landed", 100, 510, 0);

        // re-grab mid-fall
        drive_frame(1'b1, 100, 0, 2, 2, 1'b0);
        drive_frame(1'b0, 0, 0, 2, 2, 1'b0);
        for (int k = 0; k < 3; k++)
            drive_frame(1'b0, 0, 0, 2, 2, 1'b0);
        check_pos("pre_regrab", 100, 6, 2);
        drive_frame(1'b1, 200, 50, 2, 2, 1'b0);
        check_pos("regrab", 200, 50, 1);
        drive_frame(1'b0, 0, 0, 2, 2, 1'b0);
        drive_frame(1'b0, 0, 0, 2, 2, 1'b0);
        check_pos("refall_v1", 200, 51, 2);

        // frame sync: activity with vblnk low changes nothing
        vblnk_in = 1'b0;
        for (int i = 0; i < 50; i++) begin
            mouse_left = 1'($urandom_range(0, 1));
            mouse_xpos = 12'($urandom_range(0, 4095));
            mouse_ypos = 12'($urandom_range(0, 4095));
            step();
            check("sync_frame_tick", int'(frame_tick), 0);
        end
        check_pos("sync_hold", 200, 51, 2);
        mouse_left = 1'b0;

        // async reset mid-fall
        rst = 1'b1;
        #1;
        check_pos("rst_fall", 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        drive_frame(1'b1, 100, 0, 2, 2, 1'b0);
        drive_frame(1'b0, 0, 0, 2, 2, 1'b0);
        drive_frame(1'b0, 0, 0, 2, 2, 1'b0);
        check_pos("fall_after_rst", 100, 1, 2);

        // randomized frames
        for (int f = 0; f < 300; f++) begin
            bit left;
            int mx, my;
            left = ($urandom_range(0, 9) < 3);
            mx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 900));
            my = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 700));
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            drive_frame(left, mx, my, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1'b1);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
